issue_stage: RTL and testbench
==============================

Name: issue_stage

Overview:
- In-order issue stage that sits between the decoder and the execution units, including the ALU.
- Accepts decoded instructions over a decoupled handshake and reads rs1/rs2 from an internal register file, with writeback bypass.
- Blocks RAW/WAW hazards with a per-register scoreboard and presents a registered, operand-filled instruction downstream.
- Receives exec results back as the register-file write port.

Parameters:
- REG_CNT, 32, number of architectural GPRs (x0 hardwired zero).
- WB_BYPASS, 1, 1 = same-cycle writeback value forwarded to operand read and clears the hazard in the same cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- decoded  decoupled.in  -  decoded instruction from decoder; rs1_val/rs2_val fields ignored on input.
- issued  decoupled.out  -  decoded instruction with rs1_val/rs2_val filled, to exec units.
- wb  in  exec_result  -  rd_idx/rd_val from exec; rd_idx==0 means no write.
- wb_valid  in  1  wb fields valid this cycle.
- flush  in  1  squash all younger in-flight work.

Behaviour:
- Reset (rst low, async): issued.valid=0, all scoreboard pending bits=0, all GPRs=0. decoded.ready=0 while in reset.
- Operand usage is decided by op:
  - uses_rs1: all ops except LUI, AUIPC, JAL.
  - uses_rs2: OP, BRANCH, STORE.
  - writes_rd: OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD, with rd!=0.
- Hazard (combinational), true if any of:
  - uses_rs1 && rs1!=0 && pending[rs1] && !byp(rs1)
  - uses_rs2 && rs2!=0 && pending[rs2] && !byp(rs2)
  - writes_rd && pending[rd] && !byp(rd) (WAW)
  - where byp(i) = WB_BYPASS && wb_valid && wb.rd_idx==i.
- Output register advance: out_free = !issued.valid || issued.ready.
- decoded.ready = out_free && !hazard && !flush.
- Accept (decoded.valid && decoded.ready) at edge N: issued.valid=1 and issued.data loaded at N+1. Latency is 1 cycle.
- If out_free && !accept: issued.valid<=0.
- If !out_free: issued.data held stable; AXI-style, valid never drops without ready.
- Operand read:
  - x0 reads 0.
  - Otherwise, if byp(idx), use wb.rd_val; else regfile[idx].
  - Bypass has priority over the stale regfile value.
- Writeback: wb_valid && wb.rd_idx!=0 writes regfile at edge and clears pending[rd_idx]. Writes to x0 are dropped.
- Scoreboard set: on accept with writes_rd, pending[rd]<=1.
- Same-cycle set and clear on the same index: set wins, because the new instruction is younger.
- Flush (level, sampled at edge):
  - issued.valid<=0 and all pending bits<=0.
  - decoded.ready=0 that cycle; nothing is accepted.
  - A wb presented in the flush cycle still writes the regfile, since the result belongs to the older flushing instruction.
  - Exec units suppress writebacks of squashed instructions.
- Flush while issued.valid && !issued.ready: the entry is discarded regardless of ready.
- Reset asserted mid-operation: immediate clear per reset values. No partial writeback survives.
- No structural stall from wb; regfile has 2 async read ports and 1 write port.

Decomposition:
- Shared package types.sv:
  - reg_idx (5-bit) and gpreg (32-bit) typedefs.
  - Decoded-instruction struct with rs1_val/rs2_val.
  - INSTR_OP_* enum and exec_result.
  - Functions uses_rs1/uses_rs2/writes_rd.
- One sub-module: regfile. 2R1W, async read, sync write, async active-low reset, x0 hardwired, no internal bypass; bypass lives in issue_stage.

Test Plan:
- Basic issue: rst low→high, x1=5 preloaded via wb, push ADD x3,x1,x2 with issued.ready=1 → issued.valid next cycle, rs1_val=5, rs2_val=0, pending[3]=1.
- RAW stall: issue ADDI x4,x0,7, then ADD x5,x4,x4 with no wb → decoded.ready=0. Drive wb x4=7 → same cycle ready=1, next cycle rs1_val=rs2_val=7.
- Backpressure: issued.ready=0 for 3 cycles with valid entry → issued.data stable, decoded.ready=0. Ready=1 → next instruction loads next cycle.
- x0 handling: ADDI x0,x0,1 → pending unchanged; wb rd_idx=0 val=0xFFFF_FFFF → later read of x0 gives 0.
- Flush: pending[6]=1, issued.valid=1, ready=0, wb x7=9 with flush=1 → next cycle issued.valid=0, pending all 0, regfile x7=9.
- Set/clear collision: wb x8 same cycle as accepting ADDI x8,x8,1 (WB_BYPASS=1) → rs1_val=wb value, pending[8]=1 after edge.

Source files
------------

// File: rtl/issue_stage_pkg.sv
// rtl/issue_stage_pkg.sv - shared types and operand-usage helpers for the issue stage
package issue_stage_pkg;
  typedef logic [4:0]  reg_idx;
  typedef logic [31:0] gpreg;

  typedef enum logic [3:0] {
    INSTR_OP_LUI,
    INSTR_OP_AUIPC,
    INSTR_OP_JAL,
    INSTR_OP_JALR,
    INSTR_OP_BRANCH,
    INSTR_OP_LOAD,
    INSTR_OP_STORE,
    INSTR_OP_OP_IMM,
    INSTR_OP_OP
  } instr_op_e;

  typedef struct packed {
    instr_op_e op;
    reg_idx    rd;
    reg_idx    rs1;
    reg_idx    rs2;
    gpreg      imm;
    gpreg      rs1_val;
    gpreg      rs2_val;
  } decoded_instr;

  typedef struct packed {
    reg_idx rd_idx;
    gpreg   rd_val;
  } exec_result;

  function automatic logic uses_rs1(instr_op_e op);
    return !(op inside {INSTR_OP_LUI, INSTR_OP_AUIPC, INSTR_OP_JAL});
  endfunction

  function automatic logic uses_rs2(instr_op_e op);
    return op inside {INSTR_OP_OP, INSTR_OP_BRANCH, INSTR_OP_STORE};
  endfunction

  function automatic logic writes_rd(instr_op_e op, reg_idx rd);
    return (rd != '0) && (op inside {INSTR_OP_OP, INSTR_OP_OP_IMM, INSTR_OP_LUI,
                                     INSTR_OP_AUIPC, INSTR_OP_JAL, INSTR_OP_JALR,
                                     INSTR_OP_LOAD});
  endfunction
endpackage

// File: rtl/issue_stage_regfile.sv
// rtl/issue_stage_regfile.sv - 2R1W GPR file, async read, sync write, x0 hardwired to zero
module issue_stage_regfile
  import issue_stage_pkg::*;
#(
  parameter int REG_CNT = 32
) (
  input  logic   clk,
  input  logic   rst,
  input  reg_idx raddr1,
  input  reg_idx raddr2,
  output gpreg   rdata1,
  output gpreg   rdata2,
  input  logic   wen,
  input  reg_idx waddr,
  input  gpreg   wdata
);
  gpreg regs [REG_CNT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (wen && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
endmodule

// File: rtl/issue_stage.sv
// rtl/issue_stage.sv - in-order issue: scoreboard hazard check, operand read with wb bypass
module issue_stage
  import issue_stage_pkg::*;
#(
  parameter int REG_CNT   = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         decoded_valid,
  output logic         decoded_ready,
  input  decoded_instr decoded_data,
  output logic         issued_valid,
  input  logic         issued_ready,
  output decoded_instr issued_data,
  input  exec_result   wb,
  input  logic         wb_valid,
  input  logic         flush
);
  logic [REG_CNT-1:0] pending;
  logic [REG_CNT-1:0] pending_next;
  gpreg               rf_rdata1;
  gpreg               rf_rdata2;
  decoded_instr       filled;
  logic               wb_write;
  logic               wb_hit;
  logic               byp_rs1, byp_rs2, byp_rd;
  logic               hazard;
  logic               out_free;
  logic               accept;

  issue_stage_regfile #(.REG_CNT(REG_CNT)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (decoded_data.rs1),
    .raddr2 (decoded_data.rs2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .wen    (wb_write),
    .waddr  (wb.rd_idx),
    .wdata  (wb.rd_val)
  );

  assign wb_write = wb_valid && (wb.rd_idx != '0);
  assign wb_hit   = WB_BYPASS && wb_valid;
  assign byp_rs1  = wb_hit && (wb.rd_idx == decoded_data.rs1);
  assign byp_rs2  = wb_hit && (wb.rd_idx == decoded_data.rs2);
  assign byp_rd   = wb_hit && (wb.rd_idx == decoded_data.rd);

  assign hazard =
      (uses_rs1(decoded_data.op) && decoded_data.rs1 != '0 && pending[decoded_data.rs1] && !byp_rs1) ||
      (uses_rs2(decoded_data.op) && decoded_data.rs2 != '0 && pending[decoded_data.rs2] && !byp_rs2) ||
      (writes_rd(decoded_data.op, decoded_data.rd) && pending[decoded_data.rd] && !byp_rd);

  assign out_free      = !issued_valid || issued_ready;
  assign decoded_ready = rst && out_free && !hazard && !flush;
  assign accept        = decoded_valid && decoded_ready;

  // x0 is checked before bypass so a wb to x0 can never leak a value into an operand
  always_comb begin
    filled         = decoded_data;
    filled.rs1_val = (decoded_data.rs1 == '0) ? '0 : (byp_rs1 ? wb.rd_val : rf_rdata1);
    filled.rs2_val = (decoded_data.rs2 == '0) ? '0 : (byp_rs2 ? wb.rd_val : rf_rdata2);
  end

  // Set is applied after clear so a younger writer of the same rd keeps its pending bit
  always_comb begin
    pending_next = pending;
    if (wb_write) pending_next[wb.rd_idx] = 1'b0;
    if (accept && writes_rd(decoded_data.op, decoded_data.rd)) pending_next[decoded_data.rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending      <= '0;
      issued_valid <= 1'b0;
      issued_data  <= '0;
    end else if (flush) begin
      pending      <= '0;
      issued_valid <= 1'b0;
    end else begin
      pending <= pending_next;
      if (accept) begin
        issued_valid <= 1'b1;
        issued_data  <= filled;
      end else if (out_free) begin
        issued_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_issue_stage.sv
// tb/tb_issue_stage.sv - directed and randomized checks of issue_stage against a reference model
module tb_issue_stage;
  import issue_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         decoded_valid;
  logic         decoded_ready;
  decoded_instr decoded_data;
  logic         issued_valid;
  logic         issued_ready;
  decoded_instr issued_data;
  exec_result   wb;
  logic         wb_valid;
  logic         flush;

  int checks = 0;
  int errors = 0;

  // reference state: architectural registers, busy flags, one-entry output slot
  logic [31:0]  m_regs [32];
  bit           m_pend [32];
  bit           m_iv;
  decoded_instr m_idata;

  issue_stage #(.REG_CNT(32), .WB_BYPASS(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .decoded_valid (decoded_valid),
    .decoded_ready (decoded_ready),
    .decoded_data  (decoded_data),
    .issued_valid  (issued_valid),
    .issued_ready  (issued_ready),
    .issued_data   (issued_data),
    .wb            (wb),
    .wb_valid      (wb_valid),
    .flush         (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit r1(instr_op_e op);
    return !(op == INSTR_OP_LUI || op == INSTR_OP_AUIPC || op == INSTR_OP_JAL);
  endfunction
  function automatic bit r2(instr_op_e op);
    return op == INSTR_OP_OP || op == INSTR_OP_BRANCH || op == INSTR_OP_STORE;
  endfunction
  function automatic bit wr(instr_op_e op, logic [4:0] rd);
    return rd != 0 && !(op == INSTR_OP_BRANCH || op == INSTR_OP_STORE);
  endfunction

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 0;
      m_pend[i] = 0;
    end
    m_iv = 0;
    m_idata = '0;
  endtask

  function automatic logic [31:0] m_read(logic [4:0] idx);
    if (idx == 0) return 0;
    if (wb_valid && wb.rd_idx == idx) return wb.rd_val;
    return m_regs[idx];
  endfunction

  function automatic bit m_busy(logic [4:0] idx);
    return idx != 0 && m_pend[idx] && !(wb_valid && wb.rd_idx == idx);
  endfunction

  // one clock: check ready before the edge, advance model, check outputs after the edge
  task automatic step();
    bit haz, rdy, acc;
    decoded_instr d;
    #1;
    d = decoded_data;
    haz = (r1(d.op) && m_busy(d.rs1)) || (r2(d.op) && m_busy(d.rs2)) ||
          (wr(d.op, d.rd) && m_busy(d.rd));
    rdy = (!m_iv || issued_ready) && !haz && !flush;
    chk("decoded_ready", decoded_ready, rdy);
    acc = decoded_valid && rdy;
    d.rs1_val = m_read(d.rs1);
    d.rs2_val = m_read(d.rs2);
    @(posedge clk);
    if (wb_valid && wb.rd_idx != 0) m_regs[wb.rd_idx] = wb.rd_val;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
      m_iv = 0;
    end else begin
      if (wb_valid && wb.rd_idx != 0) m_pend[wb.rd_idx] = 0;
      if (acc && wr(d.op, d.rd)) m_pend[d.rd] = 1;
      if (acc) begin
        m_iv = 1;
        m_idata = d;
      end else if (!m_iv || issued_ready) begin
        m_iv = 0;
      end
    end
    @(negedge clk);
    chk("issued_valid", issued_valid, m_iv);
    if (m_iv) chk("issued_data", issued_data, m_idata);
    chk("pending", dut.pending, m_pend_vec());
  endtask

  task automatic put(input bit v, input instr_op_e op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2);
    decoded_valid = v;
    decoded_data = '0;
    decoded_data.op = op;
    decoded_data.rd = rd;
    decoded_data.rs1 = rs1;
    decoded_data.rs2 = rs2;
    decoded_data.imm = $urandom;
    decoded_data.rs1_val = $urandom;
    decoded_data.rs2_val = $urandom;
  endtask

  task automatic put_wb(input bit v, input logic [4:0] idx, input logic [31:0] val);
    wb_valid = v;
    wb.rd_idx = idx;
    wb.rd_val = val;
  endtask

  task automatic random_cycles(input int n);
    int p;
    for (int k = 0; k < n; k++) begin
      put($urandom_range(0, 3) != 0, instr_op_e'($urandom_range(0, 8)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      p = -1;
      for (int i = 1; i < 8; i++) if (m_pend[i] && $urandom_range(0, 2) == 0) p = i;
      if (p > 0) put_wb(1, 5'(p), $urandom);
      else put_wb($urandom_range(0, 7) == 0, 5'($urandom_range(0, 7)), $urandom);
      issued_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 19) == 0;
      step();
    end
  endtask

  initial begin
    rst = 1'b0;
    put(0, INSTR_OP_OP, 0, 0, 0);
    put_wb(0, 0, 0);
    issued_ready = 1'b1;
    flush = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    decoded_valid = 1'b1;
    #1;
    chk("reset_ready", decoded_ready, 1'b0);
    chk("reset_valid", issued_valid, 1'b0);
    chk("reset_pending", dut.pending, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // basic issue with x1 preloaded through wb
    put(0, INSTR_OP_OP, 0, 0, 0);
    put_wb(1, 1, 5);
    step();
    put(1, INSTR_OP_OP, 3, 1, 2);
    put_wb(0, 0, 0);
    step();
    chk("basic_rs1", issued_data.rs1_val, 5);
    chk("basic_rs2", issued_data.rs2_val, 0);
    chk("basic_pend3", dut.pending[3], 1'b1);

    // RAW stall, then release by same-cycle wb
    put(1, INSTR_OP_OP_IMM, 4, 0, 0);
    step();
    put(1, INSTR_OP_OP, 5, 4, 4);
    step();
    chk("raw_stall", decoded_ready, 1'b0);
    put_wb(1, 4, 7);
    step();
    chk("raw_rs1", issued_data.rs1_val, 7);
    chk("raw_rs2", issued_data.rs2_val, 7);
    put_wb(0, 0, 0);

    // backpressure: held entry must not change
    put(1, INSTR_OP_LUI, 9, 0, 0);
    step();
    issued_ready = 1'b0;
    put(1, INSTR_OP_LUI, 10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_rd_hold", issued_data.rd, 9);
    end
    issued_ready = 1'b1;
    step();
    chk("bp_next", issued_data.rd, 10);

    // x0 never becomes pending or nonzero
    put(1, INSTR_OP_OP_IMM, 0, 0, 0);
    put_wb(1, 0, 32'hFFFF_FFFF);
    step();
    put_wb(0, 0, 0);
    put(1, INSTR_OP_OP, 11, 0, 0);
    step();
    chk("x0_read", issued_data.rs1_val, 0);
    chk("x0_pend", dut.pending[0], 1'b0);

    // flush with a stalled entry and a wb in the same cycle
    issued_ready = 1'b0;
    put(1, INSTR_OP_OP_IMM, 6, 0, 0);
    step();
    put(0, INSTR_OP_OP, 0, 0, 0);
    put_wb(1, 7, 9);
    flush = 1'b1;
    step();
    chk("flush_valid", issued_valid, 1'b0);
    chk("flush_pend", dut.pending, 32'h0);
    flush = 1'b0;
    put_wb(0, 0, 0);
    issued_ready = 1'b1;
    put(1, INSTR_OP_OP, 12, 7, 0);
    step();
    chk("flush_x7", issued_data.rs1_val, 9);

    // set/clear collision on x8
    put(1, INSTR_OP_OP_IMM, 8, 0, 0);
    step();
    put(1, INSTR_OP_OP_IMM, 8, 8, 0);
    put_wb(1, 8, 32'h1234_5678);
    step();
    chk("coll_rs1", issued_data.rs1_val, 32'h1234_5678);
    chk("coll_pend8", dut.pending[8], 1'b1);
    put_wb(0, 0, 0);

    random_cycles(1500);

    // asynchronous reset mid-operation
    put(1, INSTR_OP_OP_IMM, 13, 0, 0);
    put_wb(1, 2, 32'hDEAD_BEEF);
    issued_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", issued_valid, 1'b0);
    chk("arst_pending", dut.pending, 32'h0);
    chk("arst_ready", decoded_ready, 1'b0);
    m_reset();
    @(negedge clk);
    put_wb(0, 0, 0);
    rst = 1'b1;
    put(1, INSTR_OP_OP, 14, 2, 1);
    issued_ready = 1'b1;
    step();
    chk("arst_x2", issued_data.rs1_val, 0);

    random_cycles(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
